writeback_stage: RTL and testbench

//  MEM/WB pipeline register plus write-back data select; the producer of the decode stage's wb_dst/wb_data/wb_en.

---
 rtl/writeback_stage.sv | 168 ++++++++++++++++
 tb/tb_writeback_stage.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register with write-back source select, register-file write port,
// processor halt state machine and retired-instruction counter.
module writeback_stage #(
   parameter int DATA_W = 16,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              stall,
   input  logic              flush,
   input  logic [31:0]       ctrl_in,
   input  logic [DATA_W-1:0] alu_res,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic [DATA_W-1:0] pc_plus2,
   input  logic [DATA_W-1:0] imm_ext,
   input  logic [DATA_W-1:0] slbi_res,
   input  logic              cond_bit,
   input  logic [DATA_W-1:0] btr_res,
   output logic [2:0]        wb_dst,
   output logic [DATA_W-1:0] wb_data,
   output logic              wb_en,
   output logic              halted,
   output logic              err,
   output logic [CNT_W-1:0]  retired
);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      HALTING = 2'd1,
      HALTED  = 2'd2
   } state_t;

   localparam logic [2:0] SEL_ALU  = 3'd0;
   localparam logic [2:0] SEL_MEM  = 3'd1;
   localparam logic [2:0] SEL_LINK = 3'd2;
   localparam logic [2:0] SEL_IMM  = 3'd3;
   localparam logic [2:0] SEL_SLBI = 3'd4;
   localparam logic [2:0] SEL_COND = 3'd5;
   localparam logic [2:0] SEL_BTR  = 3'd6;
   localparam logic [2:0] SEL_RSVD = 3'd7;

   state_t state, state_nxt;

   logic              accept;
   logic              halt_req;

   logic              vld_p1;
   logic              regwrite_p1;
   logic              halt_p1;
   logic [2:0]        dst_p1;
   logic [2:0]        sel_p1;
   logic [DATA_W-1:0] alu_p1;
   logic [DATA_W-1:0] mem_p1;
   logic [DATA_W-1:0] link_p1;
   logic [DATA_W-1:0] imm_p1;
   logic [DATA_W-1:0] slbi_p1;
   logic              cond_p1;
   logic [DATA_W-1:0] btr_p1;

   logic              unused_ctrl;
   assign unused_ctrl = ^{ctrl_in[31:11], ctrl_in[9:7]};

   function automatic logic [DATA_W-1:0] wb_select(
      input logic [2:0]        sel,
      input logic [DATA_W-1:0] alu_v,
      input logic [DATA_W-1:0] mem_v,
      input logic [DATA_W-1:0] link_v,
      input logic [DATA_W-1:0] imm_v,
      input logic [DATA_W-1:0] slbi_v,
      input logic              cond_v,
      input logic [DATA_W-1:0] btr_v
   );
      logic [DATA_W-1:0] res;
      res = '0;
      case (sel)
         SEL_ALU:  res = alu_v;
         SEL_MEM:  res = mem_v;
         SEL_LINK: res = link_v;
         SEL_IMM:  res = imm_v;
         SEL_SLBI: res = slbi_v;
         SEL_COND: res = {{(DATA_W-1){1'b0}}, cond_v};
         SEL_BTR:  res = btr_v;
         default:  res = '0;
      endcase
      return res;
   endfunction

   assign in_ready = !stall && (state == RUN);
   assign accept   = in_valid && in_ready;
   assign halt_req = accept && !flush && ctrl_in[10];

   // Stage p0 -> p1: MEM/WB register; a stall freezes everything including the counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_p1      <= 1'b0;
         regwrite_p1 <= 1'b0;
         halt_p1     <= 1'b0;
         dst_p1      <= '0;
         sel_p1      <= '0;
         alu_p1      <= '0;
         mem_p1      <= '0;
         link_p1     <= '0;
         imm_p1      <= '0;
         slbi_p1     <= '0;
         cond_p1     <= 1'b0;
         btr_p1      <= '0;
      end else if (!stall) begin
         if (accept) begin
            vld_p1      <= !flush;
            regwrite_p1 <= ctrl_in[6];
            halt_p1     <= ctrl_in[10];
            dst_p1      <= ctrl_in[2:0];
            sel_p1      <= ctrl_in[5:3];
            alu_p1      <= alu_res;
            mem_p1      <= mem_rdata;
            link_p1     <= pc_plus2;
            imm_p1      <= imm_ext;
            slbi_p1     <= slbi_res;
            cond_p1     <= cond_bit;
            btr_p1      <= btr_res;
         end else begin
            vld_p1      <= 1'b0;
         end
      end
   end

   // An instruction retires on the edge that moves it out of the p1 register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         retired <= '0;
      end else if (vld_p1 && !stall) begin
         retired <= retired + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= RUN;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         RUN: begin
            if (halt_req) state_nxt = HALTING;
         end
         HALTING: begin
            // p1 holds the halt instruction until the first unstalled edge retires it
            if (!stall && vld_p1 && halt_p1) state_nxt = HALTED;
         end
         HALTED:  state_nxt = HALTED;
         default: state_nxt = RUN;
      endcase
   end

   // Stage p1 outputs: driven only from the latched register
   assign wb_dst  = dst_p1;
   assign wb_data = wb_select(sel_p1, alu_p1, mem_p1, link_p1, imm_p1, slbi_p1, cond_p1, btr_p1);
   assign wb_en   = vld_p1 && regwrite_p1 && (sel_p1 != SEL_RSVD);
   assign err     = vld_p1 && regwrite_p1 && (sel_p1 == SEL_RSVD);
   assign halted  = (state == HALTED);

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage built with CNT_W=4 so counter wrap is reachable.
module tb_writeback_stage;

   localparam int DATA_W = 16;
   localparam int CNT_W  = 4;

   logic              clk;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic              stall;
   logic              flush;
   logic [31:0]       ctrl_in;
   logic [DATA_W-1:0] alu_res;
   logic [DATA_W-1:0] mem_rdata;
   logic [DATA_W-1:0] pc_plus2;
   logic [DATA_W-1:0] imm_ext;
   logic [DATA_W-1:0] slbi_res;
   logic              cond_bit;
   logic [DATA_W-1:0] btr_res;
   logic [2:0]        wb_dst;
   logic [DATA_W-1:0] wb_data;
   logic              wb_en;
   logic              halted;
   logic              err;
   logic [CNT_W-1:0]  retired;

   int nvec;
   int nfail;

   writeback_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .stall(stall), .flush(flush), .ctrl_in(ctrl_in),
      .alu_res(alu_res), .mem_rdata(mem_rdata), .pc_plus2(pc_plus2),
      .imm_ext(imm_ext), .slbi_res(slbi_res), .cond_bit(cond_bit),
      .btr_res(btr_res), .wb_dst(wb_dst), .wb_data(wb_data), .wb_en(wb_en),
      .halted(halted), .err(err), .retired(retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mk(input logic halt, input logic rw,
                                      input logic [2:0] sel, input logic [2:0] dst);
      return {21'b0, halt, 3'b000, rw, sel, dst};
   endfunction

   // Outputs are sampled 1 time unit after the active edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      stall    = 1'b0;
      flush    = 1'b0;
      ctrl_in  = '0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      idle();
      alu_res = '0; mem_rdata = '0; pc_plus2 = '0; imm_ext = '0;
      slbi_res = '0; cond_bit = 1'b0; btr_res = '0;
      #2;
      nvec++; if (wb_en !== 1'b0) begin nfail++; $display("FAIL reset_wb_en got %0b want 0", wb_en); end
      nvec++; if (wb_dst !== 3'd0) begin nfail++; $display("FAIL reset_wb_dst got %0d want 0", wb_dst); end
      nvec++; if (wb_data !== 16'h0) begin nfail++; $display("FAIL reset_wb_data got %h want 0000", wb_data); end
      nvec++; if (halted !== 1'b0) begin nfail++; $display("FAIL reset_halted got %0b want 0", halted); end
      nvec++; if (err !== 1'b0) begin nfail++; $display("FAIL reset_err got %0b want 0", err); end
      nvec++; if (retired !== 4'd0) begin nfail++; $display("FAIL reset_retired got %0d want 0", retired); end
      tick();
      tick();
      rst = 1'b1;
      nvec++; if (in_ready !== 1'b1) begin nfail++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
   endtask

   task automatic test_add();
      in_valid = 1'b1;
      ctrl_in  = mk(1'b0, 1'b1, 3'd0, 3'd5);
      alu_res  = 16'h1234;
      tick();
      in_valid = 1'b0;
      nvec++; if (wb_en !== 1'b1) begin nfail++; $display("FAIL add_wb_en got %0b want 1", wb_en); end
      nvec++; if (wb_dst !== 3'd5) begin nfail++; $display("FAIL add_wb_dst got %0d want 5", wb_dst); end
      nvec++; if (wb_data !== 16'h1234) begin nfail++; $display("FAIL add_wb_data got %h want 1234", wb_data); end
      tick();
      nvec++; if (retired !== 4'd1) begin nfail++; $display("FAIL add_retired got %0d want 1", retired); end
      nvec++; if (wb_en !== 1'b0) begin nfail++; $display("FAIL add_bubble_wb_en got %0b want 0", wb_en); end
   endtask

   task automatic test_sources();
      logic [DATA_W-1:0] exp_data [8];
      logic              exp_en   [8];
      alu_res = 16'h1111; mem_rdata = 16'h2222; pc_plus2 = 16'h3333; imm_ext = 16'h4444;
      slbi_res = 16'h5555; cond_bit = 1'b1; btr_res = 16'h6666;
      exp_data[0] = 16'h1111; exp_data[1] = 16'h2222; exp_data[2] = 16'h3333;
      exp_data[3] = 16'h4444; exp_data[4] = 16'h5555; exp_data[5] = 16'h0001;
      exp_data[6] = 16'h6666; exp_data[7] = 16'h0000;
      for (int i = 0; i < 8; i++) exp_en[i] = (i != 7);
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         ctrl_in  = mk(1'b0, 1'b1, 3'(i), 3'(7 - i));
         tick();
         nvec++; if (wb_data !== exp_data[i]) begin nfail++; $display("FAIL src%0d_data got %h want %h", i, wb_data, exp_data[i]); end
         nvec++; if (wb_en !== exp_en[i]) begin nfail++; $display("FAIL src%0d_wb_en got %0b want %0b", i, wb_en, exp_en[i]); end
         nvec++; if (err !== !exp_en[i]) begin nfail++; $display("FAIL src%0d_err got %0b want %0b", i, err, !exp_en[i]); end
         nvec++; if (wb_dst !== 3'(7 - i)) begin nfail++; $display("FAIL src%0d_dst got %0d want %0d", i, wb_dst, 7 - i); end
      end
      in_valid = 1'b0;
      tick();
      nvec++; if (err !== 1'b0) begin nfail++; $display("FAIL src_err_clear got %0b want 0", err); end
      nvec++; if (retired !== 4'd9) begin nfail++; $display("FAIL src_retired got %0d want 9", retired); end
   endtask

   task automatic test_stall_flush();
      in_valid  = 1'b1;
      ctrl_in   = mk(1'b0, 1'b1, 3'd1, 3'd3);
      mem_rdata = 16'hBEEF;
      tick();
      in_valid  = 1'b0;
      stall     = 1'b1;
      mem_rdata = 16'hDEAD;
      for (int i = 0; i < 3; i++) begin
         // stall wins over flush and a presented instruction
         in_valid = (i == 1);
         flush    = (i == 1);
         ctrl_in  = mk(1'b0, 1'b1, 3'd0, 3'd6);
         #1;
         nvec++; if (in_ready !== 1'b0) begin nfail++; $display("FAIL stall%0d_in_ready got %0b want 0", i, in_ready); end
         tick();
         nvec++; if (wb_en !== 1'b1) begin nfail++; $display("FAIL stall%0d_wb_en got %0b want 1", i, wb_en); end
         nvec++; if (wb_dst !== 3'd3) begin nfail++; $display("FAIL stall%0d_dst got %0d want 3", i, wb_dst); end
         nvec++; if (wb_data !== 16'hBEEF) begin nfail++; $display("FAIL stall%0d_data got %h want beef", i, wb_data); end
         nvec++; if (retired !== 4'd9) begin nfail++; $display("FAIL stall%0d_retired got %0d want 9", i, retired); end
      end
      stall    = 1'b0;
      flush    = 1'b1;
      in_valid = 1'b1;
      ctrl_in  = mk(1'b0, 1'b1, 3'd0, 3'd2);
      tick();
      idle();
      nvec++; if (wb_en !== 1'b0) begin nfail++; $display("FAIL flush_wb_en got %0b want 0", wb_en); end
      nvec++; if (retired !== 4'd10) begin nfail++; $display("FAIL flush_ld_retired got %0d want 10", retired); end
      tick();
      nvec++; if (retired !== 4'd10) begin nfail++; $display("FAIL flush_bubble_retired got %0d want 10", retired); end
   endtask

   task automatic test_flushed_halt();
      in_valid = 1'b1;
      flush    = 1'b1;
      ctrl_in  = mk(1'b1, 1'b1, 3'd0, 3'd1);
      tick();
      idle();
      nvec++; if (in_ready !== 1'b1) begin nfail++; $display("FAIL fhalt_in_ready got %0b want 1", in_ready); end
      nvec++; if (wb_en !== 1'b0) begin nfail++; $display("FAIL fhalt_wb_en got %0b want 0", wb_en); end
      tick();
      nvec++; if (halted !== 1'b0) begin nfail++; $display("FAIL fhalt_halted got %0b want 0", halted); end
      nvec++; if (retired !== 4'd10) begin nfail++; $display("FAIL fhalt_retired got %0d want 10", retired); end
   endtask

   task automatic test_halt();
      in_valid = 1'b1;
      ctrl_in  = mk(1'b1, 1'b1, 3'd0, 3'd7);
      alu_res  = 16'hABCD;
      tick();
      ctrl_in  = mk(1'b0, 1'b1, 3'd0, 3'd1);
      alu_res  = 16'h5555;
      nvec++; if (in_ready !== 1'b0) begin nfail++; $display("FAIL halt_in_ready got %0b want 0", in_ready); end
      nvec++; if (halted !== 1'b0) begin nfail++; $display("FAIL halt_early got %0b want 0", halted); end
      nvec++; if (wb_en !== 1'b1) begin nfail++; $display("FAIL halt_wb_en got %0b want 1", wb_en); end
      nvec++; if (wb_data !== 16'hABCD) begin nfail++; $display("FAIL halt_wb_data got %h want abcd", wb_data); end
      tick();
      nvec++; if (halted !== 1'b1) begin nfail++; $display("FAIL halt_halted got %0b want 1", halted); end
      nvec++; if (wb_en !== 1'b0) begin nfail++; $display("FAIL halt_post_wb_en got %0b want 0", wb_en); end
      nvec++; if (retired !== 4'd11) begin nfail++; $display("FAIL halt_retired got %0d want 11", retired); end
      tick();
      tick();
      nvec++; if (retired !== 4'd11) begin nfail++; $display("FAIL halt_frozen_retired got %0d want 11", retired); end
      nvec++; if (in_ready !== 1'b0) begin nfail++; $display("FAIL halt_frozen_ready got %0b want 0", in_ready); end
      nvec++; if (halted !== 1'b1) begin nfail++; $display("FAIL halt_terminal got %0b want 1", halted); end
      in_valid = 1'b0;
   endtask

   task automatic test_async_reset();
      // reset from HALTED, asserted between edges
      #2;
      rst = 1'b0;
      #1;
      nvec++; if (halted !== 1'b0) begin nfail++; $display("FAIL areset_halted got %0b want 0", halted); end
      nvec++; if (retired !== 4'd0) begin nfail++; $display("FAIL areset_retired got %0d want 0", retired); end
      rst = 1'b1;
      tick();
      in_valid = 1'b1;
      ctrl_in  = mk(1'b0, 1'b1, 3'd3, 3'd4);
      imm_ext  = 16'h0F0F;
      tick();
      tick();
      in_valid = 1'b0;
      nvec++; if (wb_en !== 1'b1) begin nfail++; $display("FAIL areset_pre_wb_en got %0b want 1", wb_en); end
      nvec++; if (retired !== 4'd1) begin nfail++; $display("FAIL areset_pre_retired got %0d want 1", retired); end
      #2;
      rst = 1'b0;
      #1;
      nvec++; if (wb_en !== 1'b0) begin nfail++; $display("FAIL areset_wb_en got %0b want 0", wb_en); end
      nvec++; if (wb_data !== 16'h0) begin nfail++; $display("FAIL areset_wb_data got %h want 0000", wb_data); end
      nvec++; if (retired !== 4'd0) begin nfail++; $display("FAIL areset_mid_retired got %0d want 0", retired); end
      rst = 1'b1;
      tick();
      nvec++; if (wb_en !== 1'b0) begin nfail++; $display("FAIL areset_after_wb_en got %0b want 0", wb_en); end
   endtask

   task automatic test_wrap();
      for (int k = 1; k <= 16; k++) begin
         in_valid = 1'b1;
         ctrl_in  = mk(1'b0, 1'b0, 3'd0, 3'd0);
         tick();
      end
      in_valid = 1'b0;
      nvec++; if (retired !== 4'd15) begin nfail++; $display("FAIL wrap_15 got %0d want 15", retired); end
      nvec++; if (wb_en !== 1'b0) begin nfail++; $display("FAIL wrap_nowrite got %0b want 0", wb_en); end
      tick();
      nvec++; if (retired !== 4'd0) begin nfail++; $display("FAIL wrap_0 got %0d want 0", retired); end
   endtask

   initial begin
      nvec  = 0;
      nfail = 0;
      test_reset();
      test_add();
      test_sources();
      test_stall_flush();
      test_flushed_halt();
      test_halt();
      test_async_reset();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
